// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port, with registered one-hot write decode.
// Optional RF_ARB_ZERO_FILTER_EN: accepted writes to register 0 are dropped (no strobe, no one-hot bit).
module rf_write_arbiter #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [5*N_REQ-1:0]      req_addr,
    input  logic [DATA_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    wr_en,
    output logic [31:0]             wr_onehot,
    output logic [4:0]              wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic [CNT_W-1:0]        conflict_cnt
);

    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  last;
    logic [PTR_W-1:0]  win_idx;
    logic              found;
    logic              transfer;
    logic              do_write;
    logic              contention;
    logic [4:0]        win_addr;
    logic [DATA_W-1:0] win_data;

    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(last) + 1 + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                win_idx = PTR_W'(idx);
            end
        end
        req_ready = '0;
        if (!rst && !hold && found)
            req_ready[win_idx] = 1'b1;
    end

    assign transfer   = |req_ready;
    assign win_addr   = req_addr[int'(win_idx)*5 +: 5];
    assign win_data   = req_data[int'(win_idx)*DATA_W +: DATA_W];
    assign contention = ($countones(req_valid) >= 2) && !hold;

`ifdef RF_ARB_ZERO_FILTER_EN
    // Register 0 is hardwired: accept the request but suppress the write strobe.
    assign do_write = transfer && (win_addr != 5'd0);
`else
    assign do_write = transfer;
`endif

    assign wr_en = (state == WRITE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last         <= PTR_W'(N_REQ - 1);
            wr_onehot    <= '0;
            wr_addr      <= '0;
            wr_data      <= '0;
            conflict_cnt <= '0;
        end else begin
            state     <= do_write ? WRITE : IDLE;
            wr_onehot <= do_write ? (32'd1 << win_addr) : 32'd0;
            if (transfer) begin
                last    <= win_idx;
                wr_addr <= win_addr;
                wr_data <= win_data;
            end
            if (contention && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule
